// File: rtl/demux2_n_buf_if.sv
// demux2_n_buf_if: stream bundle for the buffered 1-to-2 demultiplexer.
//   in_*   : producer side (in_data/in_sel/in_valid in, in_ready back)
//   a_*/b_*: two consumer channels (data/valid out, ready in)
//   a_count/b_count: saturating per-channel delivery counters
// slave  = demux side, master = producer/consumer side (testbench).
interface demux2_n_buf_if #(
    parameter int N = 32
);
    logic [N-1:0] in_data;
    logic         in_sel;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] a_data;
    logic         a_valid;
    logic         a_ready;
    logic [N-1:0] b_data;
    logic         b_valid;
    logic         b_ready;
    logic [15:0]  a_count;
    logic [15:0]  b_count;

    modport slave (
        input  in_data, in_sel, in_valid, a_ready, b_ready,
        output in_ready, a_data, a_valid, b_data, b_valid, a_count, b_count
    );

    modport master (
        output in_data, in_sel, in_valid, a_ready, b_ready,
        input  in_ready, a_data, a_valid, b_data, b_valid, a_count, b_count
    );
endinterface

// File: rtl/demux2_n_buf.sv
// demux2_n_buf: buffered 1-to-2 N-bit stream demultiplexer.
// Each accepted input word is steered by in_sel into one of two 2-entry
// queues (A = sel 0, B = sel 1). Queue heads, valids and delivery counters
// are pure register outputs; in_ready depends only on in_sel, reset_n and
// registered occupancy, so downstream back-pressure never reaches the input
// combinationally.
// Ports:
//   clk     : rising-edge clock
//   reset_n : synchronous active-low reset
//   bus     : demux2_n_buf_if.slave (input stream, channels A/B, counters)

// One output channel: 2-entry FIFO with registered head and a saturating
// pop counter. ent0 is always the head; ent1 is the second slot.
module demux2_n_buf_q #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         push,
    input  logic         rdy,
    input  logic [N-1:0] din,
    output logic [N-1:0] head,
    output logic         vld,
    output logic         full,
    output logic [15:0]  count
);
    logic [1:0]   occ_q, occ_d;
    logic [N-1:0] ent0_q, ent0_d;
    logic [N-1:0] ent1_q, ent1_d;
    logic [15:0]  cnt_q, cnt_d;
    logic         do_pop, do_push;

    always_comb begin
        occ_d   = occ_q;
        ent0_d  = ent0_q;
        ent1_d  = ent1_q;
        cnt_d   = cnt_q;
        do_pop  = (occ_q != 2'd0) & rdy;
        // push is already qualified by in_ready upstream; the full guard
        // keeps the queue safe regardless
        do_push = push & (occ_q != 2'd2);
        case ({do_push, do_pop})
            2'b01: begin
                occ_d = occ_q - 2'd1;
                // shift only when a second word exists; an emptied head
                // keeps its last value
                if (occ_q == 2'd2) ent0_d = ent1_q;
            end
            2'b10: begin
                occ_d = occ_q + 2'd1;
                if (occ_q == 2'd0) ent0_d = din;
                else               ent1_d = din;
            end
            // push+pop only possible at occ=1: new word becomes the head
            2'b11: ent0_d = din;
            default: ;
        endcase
        if (do_pop && (cnt_q != 16'hFFFF)) cnt_d = cnt_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            occ_q  <= 2'd0;
            ent0_q <= '0;
            ent1_q <= '0;
            cnt_q  <= 16'd0;
        end else begin
            occ_q  <= occ_d;
            ent0_q <= ent0_d;
            ent1_q <= ent1_d;
            cnt_q  <= cnt_d;
        end
    end

    assign head  = ent0_q;
    assign vld   = (occ_q != 2'd0);
    assign full  = (occ_q == 2'd2);
    assign count = cnt_q;
endmodule

module demux2_n_buf #(
    parameter int N = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    demux2_n_buf_if.slave    bus
);
    localparam int NCH = 2;

    logic [NCH-1:0]         full;
    logic [NCH-1:0]         vld;
    logic [NCH-1:0]         rdy;
    logic [NCH-1:0]         push;
    logic [NCH-1:0][N-1:0]  head;
    logic [NCH-1:0][15:0]   cnt;

    assign rdy         = {bus.b_ready, bus.a_ready};
    assign bus.in_ready = reset_n & ~full[bus.in_sel];

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        assign push[i] = bus.in_valid & bus.in_ready & (bus.in_sel == 1'(i));
        demux2_n_buf_q #(.N(N)) u_q (
            .clk     (clk),
            .reset_n (reset_n),
            .push    (push[i]),
            .rdy     (rdy[i]),
            .din     (bus.in_data),
            .head    (head[i]),
            .vld     (vld[i]),
            .full    (full[i]),
            .count   (cnt[i])
        );
    end

    assign bus.a_data  = head[0];
    assign bus.a_valid = vld[0];
    assign bus.a_count = cnt[0];
    assign bus.b_data  = head[1];
    assign bus.b_valid = vld[1];
    assign bus.b_count = cnt[1];
endmodule

// File: tb/tb_demux2_n_buf.sv
// tb_demux2_n_buf: directed checks of reset, routing, back-pressure,
// full-with-pop, mid-operation reset, a modelled random-ready stream and
// counter saturation for demux2_n_buf.
module tb_demux2_n_buf;
    logic clk = 1'b0;
    logic reset_n;
    int   n_chk  = 0;
    int   n_pass = 0;
    logic [31:0] qa[$];
    logic [31:0] qb[$];

    always #5 clk = ~clk;

    demux2_n_buf_if #(.N(32)) bus ();

    demux2_n_buf #(.N(32)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
        else n_pass++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int  idx, cyc, na, nb;
        logic exp_rdy, pa, pb;

        reset_n      = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_sel   = 1'b0;
        bus.in_data  = 32'hDEADBEEF;
        bus.a_ready  = 1'b1;
        bus.b_ready  = 1'b1;

        // ---- reset ----
        #2;
        chk("rst_in_ready0", 32'(bus.in_ready), 32'd0);
        tick();
        tick();
        chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
        chk("rst_a_valid", 32'(bus.a_valid), 32'd0);
        chk("rst_b_valid", 32'(bus.b_valid), 32'd0);
        chk("rst_a_count", 32'(bus.a_count), 32'd0);
        chk("rst_b_count", 32'(bus.b_count), 32'd0);
        chk("rst_a_data", bus.a_data, 32'd0);
        bus.in_valid = 1'b0;
        reset_n      = 1'b1;
        #1;
        chk("rel_in_ready", 32'(bus.in_ready), 32'd1);
        tick();

        // ---- routing ----
        bus.in_valid = 1'b1; bus.in_sel = 1'b0; bus.in_data = 32'h11111111;
        #1;
        chk("rt_in_ready_a", 32'(bus.in_ready), 32'd1);
        tick();
        bus.in_sel = 1'b1; bus.in_data = 32'h22222222;
        #1;
        chk("rt_a_valid", 32'(bus.a_valid), 32'd1);
        chk("rt_a_data", bus.a_data, 32'h11111111);
        chk("rt_in_ready_b", 32'(bus.in_ready), 32'd1);
        tick();
        bus.in_valid = 1'b0;
        #1;
        chk("rt_b_valid", 32'(bus.b_valid), 32'd1);
        chk("rt_b_data", bus.b_data, 32'h22222222);
        chk("rt_a_empty", 32'(bus.a_valid), 32'd0);
        chk("rt_a_count", 32'(bus.a_count), 32'd1);
        tick();
        chk("rt_b_empty", 32'(bus.b_valid), 32'd0);
        chk("rt_b_count", 32'(bus.b_count), 32'd1);

        // ---- back-pressure on A, B word slips past ----
        bus.a_ready = 1'b0;
        bus.in_valid = 1'b1; bus.in_sel = 1'b0; bus.in_data = 32'hA0;
        #1; chk("bp_acc_a0", 32'(bus.in_ready), 32'd1);
        tick();
        bus.in_data = 32'hA1;
        #1; chk("bp_acc_a1", 32'(bus.in_ready), 32'd1);
        tick();
        bus.in_data = 32'hA2;
        #1;
        chk("bp_full_a2", 32'(bus.in_ready), 32'd0);
        chk("bp_head_a0", bus.a_data, 32'hA0);
        bus.in_sel = 1'b1; bus.in_data = 32'hB0;
        #1; chk("bp_acc_b0", 32'(bus.in_ready), 32'd1);
        tick();
        // full A with a pop this cycle: still not ready
        bus.in_sel = 1'b0; bus.in_data = 32'hA2; bus.a_ready = 1'b1;
        #1;
        chk("fp_full_pop", 32'(bus.in_ready), 32'd0);
        chk("bp_b_data", bus.b_data, 32'hB0);
        chk("bp_pop_a0", bus.a_data, 32'hA0);
        tick();
        #1;
        chk("fp_ready_next", 32'(bus.in_ready), 32'd1);
        chk("bp_head_a1", bus.a_data, 32'hA1);
        tick();
        bus.in_valid = 1'b0;
        #1;
        chk("bp_a_valid_a2", 32'(bus.a_valid), 32'd1);
        chk("bp_head_a2", bus.a_data, 32'hA2);
        tick();
        chk("bp_a_drained", 32'(bus.a_valid), 32'd0);
        chk("bp_a_count", 32'(bus.a_count), 32'd4);
        chk("bp_b_count", 32'(bus.b_count), 32'd2);

        // ---- reset mid-operation ----
        bus.a_ready = 1'b0; bus.b_ready = 1'b0;
        bus.in_valid = 1'b1; bus.in_sel = 1'b0; bus.in_data = 32'hC0; tick();
        bus.in_data = 32'hC1; tick();
        bus.in_sel = 1'b1; bus.in_data = 32'hD0; tick();
        bus.in_sel = 1'b0;
        #1;
        chk("mr_a_full", 32'(bus.in_ready), 32'd0);
        chk("mr_b_valid", 32'(bus.b_valid), 32'd1);
        reset_n = 1'b0; bus.in_sel = 1'b1;
        #1;
        chk("mr_rst_ready", 32'(bus.in_ready), 32'd0);
        tick();
        reset_n = 1'b1; bus.in_valid = 1'b0; bus.a_ready = 1'b1; bus.b_ready = 1'b1;
        #1;
        chk("mr_a_valid", 32'(bus.a_valid), 32'd0);
        chk("mr_b_valid0", 32'(bus.b_valid), 32'd0);
        chk("mr_a_count", 32'(bus.a_count), 32'd0);
        chk("mr_b_count", 32'(bus.b_count), 32'd0);
        chk("mr_in_ready", 32'(bus.in_ready), 32'd1);
        tick();
        chk("mr_no_ghost", 32'({bus.a_valid, bus.b_valid}), 32'd0);

        // ---- streaming, random readies, against a queue model ----
        idx = 0; cyc = 0; na = 0; nb = 0;
        while ((idx < 100 || qa.size() != 0 || qb.size() != 0) && cyc < 2000) begin
            bus.a_ready  = 1'($urandom_range(0, 1));
            bus.b_ready  = 1'($urandom_range(0, 1));
            bus.in_valid = (idx < 100);
            bus.in_sel   = idx[0];
            bus.in_data  = 32'h5000_0000 + 32'(idx);
            #1;
            exp_rdy = bus.in_sel ? (qb.size() < 2) : (qa.size() < 2);
            chk("s_in_ready", 32'(bus.in_ready), 32'(exp_rdy));
            chk("s_a_valid", 32'(bus.a_valid), 32'(qa.size() != 0));
            chk("s_b_valid", 32'(bus.b_valid), 32'(qb.size() != 0));
            if (qa.size() != 0) chk("s_a_data", bus.a_data, qa[0]);
            if (qb.size() != 0) chk("s_b_data", bus.b_data, qb[0]);
            pa = (qa.size() != 0) && bus.a_ready;
            pb = (qb.size() != 0) && bus.b_ready;
            if (pa) begin void'(qa.pop_front()); na++; end
            if (pb) begin void'(qb.pop_front()); nb++; end
            if (idx < 100 && exp_rdy) begin
                if (bus.in_sel) qb.push_back(bus.in_data);
                else            qa.push_back(bus.in_data);
                idx++;
            end
            tick();
            cyc++;
        end
        bus.in_valid = 1'b0;
        chk("s_done", 32'(cyc < 2000), 32'd1);
        chk("s_a_count", 32'(bus.a_count), 32'd50);
        chk("s_b_count", 32'(bus.b_count), 32'd50);
        chk("s_total", 32'(bus.a_count) + 32'(bus.b_count), 32'd100);

        // ---- counter saturation on A ----
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1; bus.in_valid = 1'b1; bus.in_sel = 1'b0;
        bus.in_data = 32'h0; bus.a_ready = 1'b1;
        // first edge only pushes; every later edge pops one word
        repeat (65535) tick();
        chk("sat_fffe", 32'(bus.a_count), 32'h0000FFFE);
        tick();
        chk("sat_ffff", 32'(bus.a_count), 32'h0000FFFF);
        repeat (3) tick();
        chk("sat_hold", 32'(bus.a_count), 32'h0000FFFF);
        chk("sat_b_count", 32'(bus.b_count), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
